// File: rtl/cache_lookup_pkg.sv
// ----------------------------------------------------------------------------
// cache_lookup_pkg
// Shared types and constants for the 2-way cache metadata lookup block.
//   lookup_state_t : control FSM states (IDLE, LOOKUP, FILL)
//   way_t          : way identifier (1 bit for a 2-way cache)
//   NUM_WAYS       : associativity
// ----------------------------------------------------------------------------
package cache_lookup_pkg;

  localparam int NUM_WAYS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2
  } lookup_state_t;

  typedef logic way_t;

endpackage

// File: rtl/way_compare.sv
// ----------------------------------------------------------------------------
// way_compare
// Combinational tag match for one way of the selected set.
//   valid      in  : way holds a valid line
//   stored_tag in  : tag stored in this way
//   req_tag    in  : tag of the outstanding lookup
//   hit        out : valid and tags equal
// ----------------------------------------------------------------------------
module way_compare #(
  parameter int TAG_WIDTH = 24
) (
  input  logic                 valid,
  input  logic [TAG_WIDTH-1:0] stored_tag,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 hit
);

  assign hit = valid && (stored_tag == req_tag);

endmodule

// File: rtl/cache_way_lookup.sv
// ----------------------------------------------------------------------------
// cache_way_lookup
// Metadata side of a 2-way set-associative cache. Holds per-set valid, tag
// and LRU state, answers lookups with hit/miss and way, requests a line fill
// on a miss and installs the victim way when the fill completes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   lookup_req/lookup_addr   lookup request, addr = {tag, set}
//   lookup_ready             high only while idle
//   resp_valid/hit/way       one-cycle lookup result
//   fill_req/fill_way        fill request to the line-fill datapath
//   fill_done                fill complete (only honoured while filling)
//   flush                    invalidate every set (only honoured while idle)
//   hit_count/miss_count     saturating statistics, present only when the
//                            LOOKUP_STATS_EN macro is defined
// ----------------------------------------------------------------------------
module cache_way_lookup
  import cache_lookup_pkg::*;
#(
  parameter int S_INDEX   = 3,
  parameter int TAG_WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lookup_req,
  input  logic [TAG_WIDTH+S_INDEX-1:0] lookup_addr,
  output logic                         lookup_ready,
  output logic                         resp_valid,
  output logic                         resp_hit,
  output logic                         resp_way,
  output logic                         fill_req,
  output logic                         fill_way,
  input  logic                         fill_done,
  input  logic                         flush
`ifdef LOOKUP_STATS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
`endif
);

  localparam int NUM_SETS = 1 << S_INDEX;

  // Metadata lives in flops so flush and reset clear everything in one edge.
  logic [NUM_WAYS-1:0]  valid_reg [NUM_SETS];
  logic [TAG_WIDTH-1:0] tag_reg   [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0]  lru_reg;   // per set: way to evict next

  lookup_state_t        state_reg;
  logic [TAG_WIDTH-1:0] req_tag_reg;
  logic [S_INDEX-1:0]   req_set_reg;
  way_t                 victim_reg;

  logic [NUM_WAYS-1:0]  hit_vec;
  logic [NUM_WAYS-1:0]  set_valid;
  logic                 any_hit;
  way_t                 hit_way;
  way_t                 miss_victim;

  assign set_valid = valid_reg[req_set_reg];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      way_compare #(.TAG_WIDTH(TAG_WIDTH)) u_cmp (
        .valid      (set_valid[gi]),
        .stored_tag (tag_reg[req_set_reg][gi]),
        .req_tag    (req_tag_reg),
        .hit        (hit_vec[gi])
      );
    end
  endgenerate

  assign any_hit = |hit_vec;
  // A double hit cannot arise legally; way 0 takes priority if it ever does.
  assign hit_way = hit_vec[0] ? 1'b0 : 1'b1;

  // Prefer an empty way (way 0 first) before evicting by LRU.
  always_comb begin
    miss_victim = lru_reg[req_set_reg];
    if (!set_valid[0])
      miss_victim = 1'b0;
    else if (!set_valid[1])
      miss_victim = 1'b1;
  end

  // Responses come straight from state so an async reset drops them at once.
  assign lookup_ready = (state_reg == IDLE);
  assign fill_req     = (state_reg == FILL);
  assign fill_way     = fill_req ? victim_reg : 1'b0;
  assign resp_valid   = ((state_reg == LOOKUP) && any_hit) ||
                        ((state_reg == FILL) && fill_done);
  assign resp_hit     = (state_reg == LOOKUP) && any_hit;
  assign resp_way     = !resp_valid ? 1'b0 :
                        (state_reg == LOOKUP) ? hit_way : victim_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      req_tag_reg <= '0;
      req_set_reg <= '0;
      victim_reg  <= 1'b0;
      lru_reg     <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_reg[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++)
          tag_reg[s][w] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush) begin
            lru_reg <= '0;
            for (int s = 0; s < NUM_SETS; s++)
              valid_reg[s] <= '0;
          end else if (lookup_req) begin
            req_tag_reg <= lookup_addr[TAG_WIDTH+S_INDEX-1:S_INDEX];
            req_set_reg <= lookup_addr[S_INDEX-1:0];
            state_reg   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (any_hit) begin
            lru_reg[req_set_reg] <= ~hit_way;
            state_reg            <= IDLE;
          end else begin
            victim_reg <= miss_victim;
            state_reg  <= FILL;
          end
        end
        FILL: begin
          if (fill_done) begin
            tag_reg[req_set_reg][victim_reg]   <= req_tag_reg;
            valid_reg[req_set_reg][victim_reg] <= 1'b1;
            lru_reg[req_set_reg]               <= ~victim_reg;
            state_reg                          <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LOOKUP_STATS_EN
  logic hit_inc;
  logic miss_inc;

  assign hit_inc  = resp_valid && resp_hit;
  assign miss_inc = resp_valid && !resp_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (miss_inc && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_way_lookup.sv
// ----------------------------------------------------------------------------
// tb_cache_way_lookup
// Self-checking bench for cache_way_lookup. Expected responses are queued
// when a lookup is issued and checked by a monitor whenever resp_valid fires.
// Inputs change 1 time unit after the rising edge; outputs sampled at the
// falling edge.
// ----------------------------------------------------------------------------
module tb_cache_way_lookup;

  localparam int S_INDEX   = 3;
  localparam int TAG_WIDTH = 24;

  logic                         clk;
  logic                         rst;
  logic                         lookup_req;
  logic [TAG_WIDTH+S_INDEX-1:0] lookup_addr;
  logic                         lookup_ready;
  logic                         resp_valid;
  logic                         resp_hit;
  logic                         resp_way;
  logic                         fill_req;
  logic                         fill_way;
  logic                         fill_done;
  logic                         flush;
`ifdef LOOKUP_STATS_EN
  logic [31:0]                  hit_count;
  logic [31:0]                  miss_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];   // {hit, way}

  cache_way_lookup #(.S_INDEX(S_INDEX), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_req   (lookup_req),
    .lookup_addr  (lookup_addr),
    .lookup_ready (lookup_ready),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_way     (resp_way),
    .fill_req     (fill_req),
    .fill_way     (fill_way),
    .fill_done    (fill_done),
    .flush        (flush)
`ifdef LOOKUP_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      logic [1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected: got hit=%0b way=%0b, required no response",
                 resp_hit, resp_way);
      end else begin
        e = exp_q.pop_front();
        if ({resp_hit, resp_way} !== e) begin
          failures++;
          $display("FAIL resp: got hit=%0b way=%0b, required hit=%0b way=%0b",
                   resp_hit, resp_way, e[1], e[0]);
        end else begin
          $display("resp ok: hit=%0b way=%0b", resp_hit, resp_way);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full lookup transaction; fill_done is raised after extra_wait cycles.
  task automatic do_lookup(input logic [TAG_WIDTH-1:0] tag,
                           input logic [S_INDEX-1:0] set,
                           input logic exp_hit, input logic exp_way,
                           input int extra_wait);
    checks++;
    if (lookup_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_before: got %0b, required 1", lookup_ready);
    end
    lookup_req  = 1'b1;
    lookup_addr = {tag, set};
    exp_q.push_back({exp_hit, exp_way});
    tick();
    lookup_req = 1'b0;
    tick();
    if (exp_hit) begin
      checks++;
      if (fill_req !== 1'b0 || lookup_ready !== 1'b1) begin
        failures++;
        $display("FAIL hit_no_fill: got fill_req=%0b ready=%0b, required 0/1",
                 fill_req, lookup_ready);
      end
    end else begin
      checks++;
      if (fill_req !== 1'b1 || fill_way !== exp_way) begin
        failures++;
        $display("FAIL fill_req: got req=%0b way=%0b, required 1/%0b",
                 fill_req, fill_way, exp_way);
      end
      repeat (extra_wait) tick();
      fill_done = 1'b1;
      tick();
      fill_done = 1'b0;
      checks++;
      if (fill_req !== 1'b0 || lookup_ready !== 1'b1) begin
        failures++;
        $display("FAIL fill_end: got fill_req=%0b ready=%0b, required 0/1",
                 fill_req, lookup_ready);
      end
    end
    $display("lookup tag=%06h set=%0d exp hit=%0b way=%0b", tag, set, exp_hit, exp_way);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (lookup_ready !== 1'b1 || resp_valid !== 1'b0 || fill_req !== 1'b0 ||
        fill_way !== 1'b0 || resp_hit !== 1'b0 || resp_way !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%0b rv=%0b fr=%0b fw=%0b, required 1/0/0/0",
               lookup_ready, resp_valid, fill_req, fill_way);
    end
    rst = 1'b0;
    tick();
    $display("reset done");
  endtask

  task automatic test_miss_fill();
    do_lookup(24'h000123, 3'd5, 1'b0, 1'b0, 2);
  endtask

  task automatic test_hit();
    do_lookup(24'h000123, 3'd5, 1'b1, 1'b0, 0);   // lru[5] becomes 1
  endtask

  task automatic test_victim_lru();
    do_lookup(24'h000456, 3'd5, 1'b0, 1'b1, 0);   // empty way1
    do_lookup(24'h000123, 3'd5, 1'b1, 1'b0, 0);   // touch way0 -> lru=1
    do_lookup(24'h000789, 3'd5, 1'b0, 1'b1, 1);   // evict way1
    do_lookup(24'h000456, 3'd5, 1'b0, 1'b0, 0);   // lru now 0
    do_lookup(24'h000789, 3'd5, 1'b1, 1'b1, 0);
  endtask

  task automatic test_flush();
    flush       = 1'b1;
    lookup_req  = 1'b1;
    lookup_addr = {24'h000456, 3'd5};
    tick();
    flush      = 1'b0;
    lookup_req = 1'b0;
    checks++;
    if (lookup_ready !== 1'b1 || fill_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_wins: got ready=%0b fill_req=%0b, required 1/0",
               lookup_ready, fill_req);
    end
    tick();
    do_lookup(24'h000456, 3'd5, 1'b0, 1'b0, 0);
    do_lookup(24'h000999, 3'd5, 1'b0, 1'b1, 0);
  endtask

  task automatic test_reset_mid_fill();
    lookup_req  = 1'b1;
    lookup_addr = {24'h000AAA, 3'd5};
    tick();
    lookup_req = 1'b0;
    tick();
    checks++;
    if (fill_req !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: got fill_req=%0b, required 1", fill_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (fill_req !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_drop: got fill_req=%0b rv=%0b, required 0/0",
               fill_req, resp_valid);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    $display("reset during fill");
    do_lookup(24'h000456, 3'd5, 1'b0, 1'b0, 0);   // set 5 invalid after reset
    do_lookup(24'h000123, 3'd5, 1'b0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 8; s++)
      if (s != 5) do_lookup(24'hABC000 + 24'(s), 3'(s), 1'b0, 1'b0, s % 3);
    for (int s = 0; s < 8; s++)
      if (s != 5) do_lookup(24'hABC000 + 24'(s), 3'(s), 1'b1, 1'b0, 0);
  endtask

`ifdef LOOKUP_STATS_EN
  task automatic test_stats();
    test_reset();
    do_lookup(24'h000111, 3'd1, 1'b0, 1'b0, 0);
    do_lookup(24'h000111, 3'd1, 1'b1, 1'b0, 0);
    do_lookup(24'h000222, 3'd1, 1'b0, 1'b1, 0);
    do_lookup(24'h000222, 3'd1, 1'b1, 1'b1, 0);
    do_lookup(24'h000111, 3'd1, 1'b1, 1'b0, 0);
    checks++;
    if (hit_count !== 32'd3 || miss_count !== 32'd2) begin
      failures++;
      $display("FAIL stats: got hits=%0d misses=%0d, required 3/2", hit_count, miss_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      failures++;
      $display("FAIL stats_rst: got hits=%0d misses=%0d, required 0/0", hit_count, miss_count);
    end
    tick();
    rst = 1'b0;
    tick();
    $display("stats checked");
  endtask
`endif

  initial begin
    rst         = 1'b1;
    lookup_req  = 1'b0;
    lookup_addr = '0;
    fill_done   = 1'b0;
    flush       = 1'b0;
    test_reset();
    test_miss_fill();
    test_hit();
    test_victim_lru();
    test_flush();
    test_reset_mid_fill();
    test_reset();
    test_back_to_back();
`ifdef LOOKUP_STATS_EN
    test_stats();
`endif
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_resp: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
